// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer: 2-flop sync, stability counter, press/release strobes.
// Auto-repeat strobes are built only when BTN_DEBOUNCE_REPEAT_EN is defined.
module btn_debounce_multi #(
    parameter int N_CH       = 5,
    parameter int STABLE_CYC = 1000000,
    parameter int REPEAT_DLY = 30000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);
    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

    typedef enum logic {PH_FIRST, PH_PERIODIC} phase_t;
`endif

    if (N_CH < 1 || STABLE_CYC < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
        $error("btn_debounce_multi: N_CH, STABLE_CYC, REPEAT_DLY and REPEAT_PER must all be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             deviate;
        logic             done;
        logic             rise;
        logic             fall;

        assign deviate = (s2 != level_q);
        assign done    = deviate && (cnt == CNT_LAST);
        assign rise    = done && s2;
        assign fall    = done && !s2;

        // Strobes are registered alongside the level so they line up with its first new cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1        <= btn_in[i];
                s2        <= s1;
                press_q   <= rise;
                release_q <= fall;
                if (!deviate) begin
                    cnt <= '0;
                end else if (done) begin
                    level_q <= s2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
        phase_t           phase;
        phase_t           phase_nxt;
        logic [RPT_W-1:0] rcnt;
        logic [RPT_W-1:0] rcnt_nxt;
        logic             rpt_q;
        logic             rpt_nxt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                phase <= PH_FIRST;
                rcnt  <= '0;
                rpt_q <= 1'b0;
            end else begin
                phase <= phase_nxt;
                rcnt  <= rcnt_nxt;
                rpt_q <= rpt_nxt;
            end
        end

        // The falling edge wins over an expiring period so no repeat shares the release cycle.
        always_comb begin
            phase_nxt = phase;
            rcnt_nxt  = rcnt;
            rpt_nxt   = 1'b0;
            if (!level_q || fall) begin
                phase_nxt = PH_FIRST;
                rcnt_nxt  = '0;
            end else if (phase == PH_FIRST && rcnt == DLY_LAST) begin
                rpt_nxt   = 1'b1;
                rcnt_nxt  = '0;
                phase_nxt = PH_PERIODIC;
            end else if (phase == PH_PERIODIC && rcnt == PER_LAST) begin
                rpt_nxt  = 1'b1;
                rcnt_nxt = '0;
            end else begin
                rcnt_nxt = rcnt + RPT_W'(1);
            end
        end

        assign btn_repeat[i] = rpt_q;
`else
        assign btn_repeat[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: vector table, directed corner sequences, random run vs reference model.
// Expectations follow BTN_DEBOUNCE_REPEAT_EN the same way the design does.
module tb_btn_debounce_multi;
    localparam int SC  = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_repeat;

    btn_debounce_multi #(
        .N_CH      (2),
        .STABLE_CYC(SC),
        .REPEAT_DLY(DLY),
        .REPEAT_PER(PER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    // Reference model: level flips once the last SC synchronised samples all disagree with it;
    // repeats fall at press+DLY, press+DLY+PER, ... while the level stays high.
    logic [1:0] e_level, e_press, e_release, e_repeat;
    bit         m_s1 [2];
    bit         m_s2 [2];
    bit         hist [2][SC];
    int         hist_n [2];
    int         m_tp [2];

    always @(posedge clk) begin
        bit dev_all;
        int el;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; hist_n[i] = 0; m_tp[i] = 0;
                for (int j = 0; j < SC; j++) hist[i][j] = 1'b0;
                e_level[i] = 1'b0; e_press[i] = 1'b0; e_release[i] = 1'b0; e_repeat[i] = 1'b0;
            end else begin
                for (int j = 0; j < SC - 1; j++) hist[i][j] = hist[i][j+1];
                hist[i][SC-1] = m_s2[i];
                if (hist_n[i] < SC) hist_n[i]++;
                dev_all = (hist_n[i] == SC);
                for (int j = 0; j < SC; j++) if (hist[i][j] == e_level[i]) dev_all = 1'b0;
                e_press[i]   = dev_all && !e_level[i];
                e_release[i] = dev_all && e_level[i];
                e_repeat[i]  = 1'b0;
                el = cyc - m_tp[i];
                if (REP_EN && e_level[i] && !dev_all && el >= DLY && ((el - DLY) % PER) == 0)
                    e_repeat[i] = 1'b1;
                if (dev_all) e_level[i] = ~e_level[i];
                if (e_press[i]) m_tp[i] = cyc;
                m_s2[i] = m_s1[i];
                m_s1[i] = btn_in[i];
            end
        end
    end

    task automatic check_output(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("model_level",   btn_level,   e_level);
            check_output("model_press",   btn_press,   e_press);
            check_output("model_release", btn_release, e_release);
            check_output("model_repeat",  btn_repeat,  e_repeat);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [1:0] v, input int n);
        btn_in = v;
        tick(n);
    endtask

    // Returns the number of edges until btn_press[ch] is seen, or -1 after 20 edges.
    task automatic wait_press(input int ch, output int lat);
        lat = -1;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (btn_press[ch]) begin
                lat = t;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] in;
        int         hold;
        logic [1:0] level;
        logic [1:0] press;
        logic [1:0] rel;
    } vec_t;

    vec_t tbl [9];
    int   lat, p_cyc;
    int   rep_off [$];
    int   exp_off [$];

    initial begin
        tbl[0] = '{2'b01, 5, 2'b00, 2'b00, 2'b00};
        tbl[1] = '{2'b01, 1, 2'b01, 2'b01, 2'b00};
        tbl[2] = '{2'b01, 1, 2'b01, 2'b00, 2'b00};
        tbl[3] = '{2'b11, 6, 2'b11, 2'b10, 2'b00};
        tbl[4] = '{2'b10, 5, 2'b11, 2'b00, 2'b00};
        tbl[5] = '{2'b10, 1, 2'b10, 2'b00, 2'b01};
        tbl[6] = '{2'b11, 2, 2'b10, 2'b00, 2'b00};
        tbl[7] = '{2'b10, 6, 2'b10, 2'b00, 2'b00};
        tbl[8] = '{2'b00, 6, 2'b00, 2'b00, 2'b10};

        rst_n  = 1'b0;
        btn_in = 2'b00;
        tick(3);
        check_en = 1'b1;
        check_output("reset_level", btn_level, 2'b00);
        check_output("reset_press", btn_press, 2'b00);
        check_output("reset_release", btn_release, 2'b00);
        check_output("reset_repeat", btn_repeat, 2'b00);
        rst_n = 1'b1;

        for (int r = 0; r < 9; r++) begin
            apply_stimulus(tbl[r].in, tbl[r].hold);
            check_output($sformatf("tbl%0d_level", r), btn_level, tbl[r].level);
            check_output($sformatf("tbl%0d_press", r), btn_press, tbl[r].press);
            check_output($sformatf("tbl%0d_release", r), btn_release, tbl[r].rel);
        end
        tick(4);

        // Held button: repeat offsets from the press cycle, then release latency.
        btn_in = 2'b01;
        wait_press(0, lat);
        check_int("press_latency", lat, SC + 2);
        p_cyc = cyc;
        for (int off = 1; off <= 20; off++) begin
            tick(1);
            if (btn_repeat[0]) rep_off.push_back(off);
        end
        if (REP_EN) exp_off = '{10, 13, 16, 19};
        check_int("repeat_count", rep_off.size(), exp_off.size());
        for (int k = 0; k < rep_off.size() && k < exp_off.size(); k++)
            check_int($sformatf("repeat_off%0d", k), rep_off[k], exp_off[k]);
        btn_in = 2'b00;
        lat = -1;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (btn_release[0]) begin
                lat = t;
                break;
            end
        end
        check_int("release_latency", lat, SC + 2);
        tick(4);

        // Release lands on the edge where the third repeat would fire.
        btn_in = 2'b01;
        wait_press(0, lat);
        p_cyc = cyc;
        tick(10);
        btn_in = 2'b00;
        tick(6);
        check_int("coincide_cycle", cyc - p_cyc, 16);
        check_output("coincide_release", btn_release, 2'b01);
        check_output("coincide_repeat", btn_repeat, 2'b00);
        tick(4);

        // One-cycle reset while ch0 is held and debounced.
        btn_in = 2'b01;
        tick(8);
        check_output("held_level", btn_level, 2'b01);
        rst_n = 1'b0;
        tick(1);
        check_output("midrst_level", btn_level, 2'b00);
        check_output("midrst_press", btn_press, 2'b00);
        check_output("midrst_release", btn_release, 2'b00);
        check_output("midrst_repeat", btn_repeat, 2'b00);
        rst_n = 1'b1;
        wait_press(0, lat);
        check_int("repress_latency", lat, SC + 2);
        apply_stimulus(2'b00, 10);

        // Both channels pressed together, ch1 released early.
        apply_stimulus(2'b11, 6);
        check_output("dual_press", btn_press, 2'b11);
        apply_stimulus(2'b11, 2);
        apply_stimulus(2'b01, 6);
        check_output("dual_release", btn_release, 2'b10);
        check_output("dual_level", btn_level, 2'b01);
        apply_stimulus(2'b01, 8);
        apply_stimulus(2'b00, 10);

        // Random hold lengths mix glitches and real presses; occasional resets.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            btn_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) < 8) tick($urandom_range(1, 3));
            else                          tick($urandom_range(4, 30));
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/btn_debounce_multi.md
Name:
btn_debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer; serves all board push-buttons (default 5: up/down/left/right/centre) in the Tetris top level.
- Per channel: 2-flop synchroniser, stability counter, debounced level, one-cycle press/release strobes.
- Optional auto-repeat strobe while a button is held, driving piece left/right/down moves.

Parameters:
- N_CH, 5, number of independent button channels.
- STABLE_CYC, 1000000, consecutive stable cycles required before the debounced level changes (10 ms at 100 MHz); legal range >= 1.
- REPEAT_DLY, 30000000, cycles from the press strobe to the first repeat strobe (300 ms); legal range >= 1.
- REPEAT_PER, 10000000, cycles between subsequent repeat strobes (100 ms); legal range >= 1.
- Counter widths are localparams derived with $clog2 of the above, never fewer than 1 bit.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  synchronous, active-low reset.
- btn_in  in  N_CH  raw asynchronous button inputs, active-high.
- btn_level  out  N_CH  debounced level.
- btn_press  out  N_CH  one-cycle strobe on debounced 0->1.
- btn_release  out  N_CH  one-cycle strobe on debounced 1->0.
- btn_repeat  out  N_CH  one-cycle auto-repeat strobe while held.

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low. On any posedge clk with rst_n=0, all synchroniser flops, counters, btn_level, btn_press, btn_release and btn_repeat clear to 0. This applies mid-operation as well. A button held through reset is seen as a fresh press, STABLE_CYC+2 cycles after rst_n returns to 1.
- Channels are fully independent, with no cross-channel interaction.
- Synchroniser: s1 <= btn_in[i]; s2 <= s1.
- Stability counter cnt:
  - If s2 == btn_level[i]: cnt <= 0.
  - Else, if cnt == STABLE_CYC-1: btn_level[i] <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: an input change held stable is sampled at edge k. btn_level changes after edge k+STABLE_CYC+1, i.e. the (STABLE_CYC+2)th edge counting from k.
- Glitch rejection: any return of s2 to btn_level before the count completes clears cnt. The next deviation restarts the count from 0.
- Strobes:
  - btn_press[i] is registered and high for exactly the one cycle in which btn_level[i] first reads 1.
  - btn_release[i] behaves the same for the first cycle btn_level[i] reads 0.
  - Strobes are never asserted while in reset.
- Auto-repeat counter rcnt (per channel):
  - Cleared on the edge that sets btn_level=1, and held at 0 while btn_level=0.
  - While btn_level=1, rcnt increments each cycle.
  - When the phase is "first" and rcnt == REPEAT_DLY-1: pulse btn_repeat, rcnt <= 0, phase <= "periodic".
  - When the phase is "periodic" and rcnt == REPEAT_PER-1: pulse btn_repeat, rcnt <= 0.
  - Phase returns to "first" on release or reset.
- Repeat timing: the first btn_repeat is exactly REPEAT_DLY cycles after the btn_press cycle. Later repeats follow every REPEAT_PER cycles.
- btn_repeat never coincides with btn_press.
- On release, btn_repeat is 0 in the btn_release cycle and afterwards, even if a repeat period would have expired on that edge.
- Counters never wrap: each is cleared on reaching its terminal value, so no overflow is possible at the derived widths.

Optional Feature:
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- Defined: auto-repeat logic as above.
- Undefined: rcnt and phase are not instantiated, and btn_repeat is tied to 0. All other behaviour and timing are identical. REPEAT_DLY and REPEAT_PER are accepted but unused.

Test Plan (N_CH=2, STABLE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3):
- Reset, then btn_in=2'b01 held from edge k -> btn_level[0]=1 and btn_press[0]=1 after edge k+5 for one cycle only; channel 1 stays 0, all other strobes 0.
- Bounce: ch0 toggles 1,0,1,0 every 2 cycles, then holds 1 -> no btn_press during the bounce; a single btn_press 6 edges after the final rising sample.
- Hold ch0 for 20 cycles after press -> btn_repeat[0] pulses at press+10, +13, +16, +19; releasing gives btn_release after STABLE_CYC+2 edges with no further repeats (with macro undefined: btn_repeat stays 0 throughout).
- Release with the repeat period coinciding: release timed so btn_level falls on the edge where rcnt would hit 2 -> btn_release=1 and btn_repeat=0 in that cycle.
- Reset mid-hold: assert rst_n=0 for 1 cycle while ch0 is held and debounced -> all outputs 0 the next cycle; btn_press reasserts 6 edges after rst_n=1.
- Simultaneous channels: both buttons pressed on the same edge, ch1 released 8 cycles later -> independent press, release and repeat strobes with identical timing per channel, no interference.
